// File: rtl/comp_decomp_pkg.sv
// Shared types for the dictionary compress/decompress engine.
package comp_decomp_pkg;

   localparam int unsigned SYMBOL_WIDTH = 80;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'b00,
      CMD_COMP   = 2'b01,
      CMD_DECOMP = 2'b10,
      CMD_RSVD   = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      RSP_NONE      = 2'b00,
      RSP_COMP_OK   = 2'b01,
      RSP_DECOMP_OK = 2'b10,
      RSP_ERR       = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_DECOMP,
      ST_REJECT
   } state_e;

endpackage

// File: rtl/comp_decomp_engine_dict_mem.sv
// Symbol dictionary: unreset register array, one sync write port, one async read port.
module comp_dict_mem
   import comp_decomp_pkg::*;
#(
   parameter int unsigned DICT_DEPTH = 16,
   parameter int unsigned AW         = 4
) (
   input  logic                    clk,
   input  logic                    we_i,
   input  logic [AW-1:0]           waddr_i,
   input  logic [SYMBOL_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]           raddr_i,
   output logic [SYMBOL_WIDTH-1:0] rdata_o
);

   logic [SYMBOL_WIDTH-1:0] mem_q [DICT_DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/comp_decomp_engine.sv
// Dictionary compress/decompress engine: linear-search FSM over comp_dict_mem.
module comp_decomp_engine
   import comp_decomp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DICT_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              command,
   input  logic [SYMBOL_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0]   compressed_in,
   output logic [DATA_WIDTH-1:0]   compressed_out,
   output logic [SYMBOL_WIDTH-1:0] decompressed_out,
   output logic [1:0]              response,
   output logic                    busy
);

   localparam int unsigned CW   = $clog2(DICT_DEPTH + 1);
   localparam int unsigned AW   = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
   localparam int unsigned CMPW = (DATA_WIDTH > CW) ? DATA_WIDTH : CW;
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] DEPTH = CW'(DICT_DEPTH);

   state_e                  state_q, state_d;
   logic [CW-1:0]           idx_q, idx_d;
   logic [CW-1:0]           count_q, count_d;
   logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
   logic [DATA_WIDTH-1:0]   cidx_q, cidx_d;
   logic [DATA_WIDTH-1:0]   cout_q, cout_d;
   logic [SYMBOL_WIDTH-1:0] dout_q, dout_d;
   resp_e                   resp_q, resp_d;

   logic                    we;
   logic [AW-1:0]           raddr;
   logic [SYMBOL_WIDTH-1:0] rdata;
   logic [CMPW-1:0]         idx_ext, count_ext, cidx_ext;

   comp_dict_mem #(
      .DICT_DEPTH (DICT_DEPTH),
      .AW         (AW)
   ) u_dict (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (sym_q),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   assign idx_ext   = CMPW'(idx_q);
   assign count_ext = CMPW'(count_q);
   assign cidx_ext  = CMPW'(cidx_q);
   assign raddr     = (state_q == ST_DECOMP) ? cidx_q[AW-1:0] : idx_q[AW-1:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      sym_d   = sym_q;
      cidx_d  = cidx_q;
      cout_d  = cout_q;
      dout_d  = dout_q;
      resp_d  = RSP_NONE;
      we      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_e'(command) != CMD_NOP) begin
               sym_d  = data_in;
               cidx_d = compressed_in;
               idx_d  = '0;
               unique case (cmd_e'(command))
                  CMD_COMP:   state_d = ST_SEARCH;
                  CMD_DECOMP: state_d = ST_DECOMP;
                  default:    state_d = ST_REJECT;
               endcase
            end
         end
         ST_SEARCH: begin
            // Entry idx is only valid below count; last probe (or empty dict) falls through to insert.
            if ((idx_q < count_q) && (rdata == sym_q)) begin
               cout_d  = idx_ext[DATA_WIDTH-1:0];
               resp_d  = RSP_COMP_OK;
               state_d = ST_IDLE;
            end else if ((idx_q + ONE) >= count_q) begin
               state_d = ST_IDLE;
               if (count_q < DEPTH) begin
                  we      = 1'b1;
                  count_d = count_q + ONE;
                  cout_d  = count_ext[DATA_WIDTH-1:0];
                  resp_d  = RSP_COMP_OK;
               end else begin
                  resp_d = RSP_ERR;
               end
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         ST_DECOMP: begin
            state_d = ST_IDLE;
            if (cidx_ext < count_ext) begin
               dout_d = rdata;
               resp_d = RSP_DECOMP_OK;
            end else begin
               resp_d = RSP_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
            resp_d  = RSP_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         count_q <= '0;
         sym_q   <= '0;
         cidx_q  <= '0;
         cout_q  <= '0;
         dout_q  <= '0;
         resp_q  <= RSP_NONE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         sym_q   <= sym_d;
         cidx_q  <= cidx_d;
         cout_q  <= cout_d;
         dout_q  <= dout_d;
         resp_q  <= resp_d;
      end
   end

   assign compressed_out   = cout_q;
   assign decompressed_out = dout_q;
   assign response         = resp_q;
   assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_comp_decomp_engine.sv
// Directed self-checking bench for comp_decomp_engine (DATA_WIDTH=8, DICT_DEPTH=16).
module tb_comp_decomp_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  command = 2'b00;
   logic [79:0] data_in = '0;
   logic [7:0]  compressed_in = '0;
   logic [7:0]  compressed_out;
   logic [79:0] decompressed_out;
   logic [1:0]  response;
   logic        busy;

   int tests = 0;
   int fails = 0;

   comp_decomp_engine #(
      .DATA_WIDTH (8),
      .DICT_DEPTH (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .command          (command),
      .data_in          (data_in),
      .compressed_in    (compressed_in),
      .compressed_out   (compressed_out),
      .decompressed_out (decompressed_out),
      .response         (response),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // Issues one command and returns cycles from accept edge to response pulse (-1 on timeout).
   task automatic run_cmd(input logic [1:0] c, input logic [79:0] d, input logic [7:0] ci,
                          output int lat, output logic [1:0] rsp);
      @(negedge clk);
      command = c; data_in = d; compressed_in = ci;
      @(posedge clk); #1;
      command = 2'b00;
      lat = -1; rsp = 2'b00;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (response !== 2'b00) begin
            lat = k; rsp = response;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (compressed_out !== 8'h00) begin fails++; $display("FAIL reset_cout got %h exp 00", compressed_out); end
      tests++; if (decompressed_out !== 80'h0) begin fails++; $display("FAIL reset_dout got %h exp 0", decompressed_out); end
      tests++; if (response !== 2'b00) begin fails++; $display("FAIL reset_resp got %b exp 00", response); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_first_compress();
      int lat; logic [1:0] rsp;
      run_cmd(2'b01, 80'hA5, 8'h00, lat, rsp);
      tests++; if (lat !== 1) begin fails++; $display("FAIL first_lat got %0d exp 1", lat); end
      tests++; if (rsp !== 2'b01) begin fails++; $display("FAIL first_resp got %b exp 01", rsp); end
      tests++; if (compressed_out !== 8'h00) begin fails++; $display("FAIL first_cout got %h exp 00", compressed_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL first_busy got %b exp 0", busy); end
      @(posedge clk); #1;
      tests++; if (response !== 2'b00) begin fails++; $display("FAIL first_pulse got %b exp 00", response); end
   endtask

   task automatic test_sequence();
      logic [79:0] syms [4] = '{80'h1, 80'h2, 80'h3, 80'h2};
      int exp_idx [4] = '{0, 1, 2, 1};
      int exp_lat [4] = '{1, 1, 2, 2};
      int lat; logic [1:0] rsp;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_cmd(2'b01, syms[i], 8'h00, lat, rsp);
         tests++; if (rsp !== 2'b01 || compressed_out !== 8'(exp_idx[i])) begin
            fails++; $display("FAIL seq_idx[%0d] got rsp %b idx %0d exp 01 idx %0d", i, rsp, compressed_out, exp_idx[i]);
         end
         tests++; if (lat !== exp_lat[i]) begin fails++; $display("FAIL seq_lat[%0d] got %0d exp %0d", i, lat, exp_lat[i]); end
      end
   endtask

   task automatic test_decompress();
      int lat; logic [1:0] rsp;
      run_cmd(2'b10, 80'h0, 8'd1, lat, rsp);
      tests++; if (lat !== 1 || rsp !== 2'b10) begin fails++; $display("FAIL dec1_resp got lat %0d rsp %b exp 1 10", lat, rsp); end
      tests++; if (decompressed_out !== 80'h2) begin fails++; $display("FAIL dec1_data got %h exp 2", decompressed_out); end
      run_cmd(2'b10, 80'h0, 8'd5, lat, rsp);
      tests++; if (lat !== 1 || rsp !== 2'b11) begin fails++; $display("FAIL dec5_resp got lat %0d rsp %b exp 1 11", lat, rsp); end
      tests++; if (decompressed_out !== 80'h2) begin fails++; $display("FAIL dec5_hold got %h exp 2", decompressed_out); end
      run_cmd(2'b10, 80'h0, 8'd3, lat, rsp);
      tests++; if (rsp !== 2'b11) begin fails++; $display("FAIL dec_eqcount got %b exp 11", rsp); end
      run_cmd(2'b10, 80'h0, 8'd2, lat, rsp);
      tests++; if (rsp !== 2'b10 || decompressed_out !== 80'h3) begin fails++; $display("FAIL dec_last got rsp %b data %h exp 10 3", rsp, decompressed_out); end
      tests++; if (compressed_out !== 8'd1) begin fails++; $display("FAIL dec_cout_hold got %0d exp 1", compressed_out); end
   endtask

   task automatic test_full();
      int lat; logic [1:0] rsp; int nf;
      do_reset();
      nf = 0;
      for (int i = 0; i < 16; i++) begin
         run_cmd(2'b01, 80'd100 + 80'(i), 8'h00, lat, rsp);
         if (rsp !== 2'b01 || compressed_out !== 8'(i) || lat !== ((i == 0) ? 1 : i)) nf++;
      end
      tests++; if (nf != 0) begin fails++; $display("FAIL fill_errors got %0d exp 0", nf); end
      run_cmd(2'b01, 80'hDEAD, 8'h00, lat, rsp);
      tests++; if (rsp !== 2'b11 || lat !== 16) begin fails++; $display("FAIL full_resp got rsp %b lat %0d exp 11 16", rsp, lat); end
      tests++; if (compressed_out !== 8'd15) begin fails++; $display("FAIL full_cout got %0d exp 15", compressed_out); end
      run_cmd(2'b10, 80'h0, 8'd16, lat, rsp);
      tests++; if (rsp !== 2'b11) begin fails++; $display("FAIL full_dec16 got %b exp 11", rsp); end
      run_cmd(2'b01, 80'd115, 8'h00, lat, rsp);
      tests++; if (rsp !== 2'b01 || compressed_out !== 8'd15 || lat !== 16) begin
         fails++; $display("FAIL full_last got rsp %b idx %0d lat %0d exp 01 15 16", rsp, compressed_out, lat);
      end
      run_cmd(2'b10, 80'h0, 8'd15, lat, rsp);
      tests++; if (rsp !== 2'b10 || decompressed_out !== 80'd115) begin fails++; $display("FAIL full_dec15 got rsp %b data %h exp 10 73", rsp, decompressed_out); end
   endtask

   task automatic test_reset_mid_search();
      int lat; logic [1:0] rsp;
      @(negedge clk); command = 2'b01; data_in = 80'hBEEF;
      @(posedge clk); #1; command = 2'b00;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      tests++; if (compressed_out !== 8'h00 || decompressed_out !== 80'h0) begin
         fails++; $display("FAIL midrst_data got cout %h dout %h exp 0 0", compressed_out, decompressed_out);
      end
      tests++; if (busy !== 1'b0 || response !== 2'b00) begin fails++; $display("FAIL midrst_ctrl got busy %b rsp %b exp 0 00", busy, response); end
      @(negedge clk); reset = 1'b0;
      run_cmd(2'b01, 80'h3, 8'h00, lat, rsp);
      tests++; if (rsp !== 2'b01 || compressed_out !== 8'd0 || lat !== 1) begin
         fails++; $display("FAIL midrst_comp got rsp %b idx %0d lat %0d exp 01 0 1", rsp, compressed_out, lat);
      end
   endtask

   task automatic test_reserved();
      int lat; logic [1:0] rsp;
      run_cmd(2'b11, 80'h77, 8'd0, lat, rsp);
      tests++; if (rsp !== 2'b11 || lat !== 1) begin fails++; $display("FAIL rsvd_resp got rsp %b lat %0d exp 11 1", rsp, lat); end
      run_cmd(2'b01, 80'h4, 8'h00, lat, rsp);
      tests++; if (compressed_out !== 8'd1 || lat !== 1) begin fails++; $display("FAIL rsvd_nochange got idx %0d lat %0d exp 1 1", compressed_out, lat); end
      run_cmd(2'b01, 80'h5, 8'h00, lat, rsp);
      tests++; if (compressed_out !== 8'd2 || lat !== 2) begin fails++; $display("FAIL comp5 got idx %0d lat %0d exp 2 2", compressed_out, lat); end
   endtask

   task automatic test_busy_ignore();
      int lat; logic [1:0] rsp;
      @(negedge clk); command = 2'b01; data_in = 80'h9;
      @(posedge clk); #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_high got %b exp 1", busy); end
      command = 2'b01; data_in = 80'h4;
      lat = -1; rsp = 2'b00;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (k == 2) command = 2'b00;
         if (response !== 2'b00) begin lat = k; rsp = response; break; end
      end
      command = 2'b00;
      tests++; if (rsp !== 2'b01 || compressed_out !== 8'd3 || lat !== 3) begin
         fails++; $display("FAIL busy_latched got rsp %b idx %0d lat %0d exp 01 3 3", rsp, compressed_out, lat);
      end
      @(posedge clk); #1;
      tests++; if (busy !== 1'b0 || response !== 2'b00) begin fails++; $display("FAIL busy_noqueue got busy %b rsp %b exp 0 00", busy, response); end
      run_cmd(2'b01, 80'h9, 8'h00, lat, rsp);
      tests++; if (compressed_out !== 8'd3 || lat !== 4) begin fails++; $display("FAIL busy_repeat9 got idx %0d lat %0d exp 3 4", compressed_out, lat); end
      run_cmd(2'b01, 80'h4, 8'h00, lat, rsp);
      tests++; if (compressed_out !== 8'd1 || lat !== 2) begin fails++; $display("FAIL busy_repeat4 got idx %0d lat %0d exp 1 2", compressed_out, lat); end
      run_cmd(2'b10, 80'h0, 8'd3, lat, rsp);
      tests++; if (rsp !== 2'b10 || decompressed_out !== 80'h9) begin fails++; $display("FAIL busy_dec3 got rsp %b data %h exp 10 9", rsp, decompressed_out); end
   endtask

   initial begin
      reset = 1'b1;
      #12 reset = 1'b0;
      test_reset();
      test_first_compress();
      test_sequence();
      test_decompress();
      test_full();
      test_reset_mid_search();
      test_reserved();
      test_busy_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
